// File: rtl/robonaut_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : robonaut_int_ctrl
// Brief   : Eight-source prioritized interrupt controller with IO-bus IMR/IPR/
//           ISR/EOI registers and an interrupt/int_ack handshake to the CU.
// Rev     : 1.0 - initial release
// ============================================================================
module robonaut_int_ctrl #(
    parameter int          NUM_SRC  = 8,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               io_cs_,
    input  logic               io_rd_,
    input  logic               io_wr_,
    input  logic [1:0]         io_addr,
    input  logic [7:0]         io_wdata,
    output logic [7:0]         io_rdata,
    output logic               interrupt,
    input  logic               int_ack,
    output logic [2:0]         int_id,
    output logic [31:0]        int_vec
);

    localparam logic [1:0] c_ADDR_IMR = 2'd0;
    localparam logic [1:0] c_ADDR_IPR = 2'd1;
    localparam logic [1:0] c_ADDR_ISR = 2'd2;
    localparam logic [1:0] c_ADDR_EOI = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_ACK    = 2'd2,
        S_REL    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_prev;
    logic [7:0] r_imr;
    logic [7:0] r_ipr;
    logic [7:0] r_isr;
    logic [2:0] r_int_id;

    logic [7:0] w_edge;
    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_isr_low;
    logic [7:0] w_prio;
    logic [7:0] w_elig;
    logic [7:0] w_win_oh;
    logic [2:0] w_win_id;
    logic       w_ack_take;
    logic [7:0] w_ipr_nxt;
    logic [7:0] w_isr_nxt;

    assign w_edge     = r_sync2 & ~r_prev;
    assign w_wr       = ~io_cs_ & ~io_wr_;
    assign w_rd       = ~io_cs_ & ~io_rd_;

    // Only sources strictly above the highest-priority in-service bit may nest.
    assign w_isr_low  = r_isr & (~r_isr + 8'd1);
    assign w_prio     = (r_isr == 8'd0) ? 8'hFF : (w_isr_low - 8'd1);
    assign w_elig     = r_ipr & ~r_imr & w_prio;
    assign w_win_oh   = w_elig & (~w_elig + 8'd1);
    assign w_ack_take = (r_state == S_ASSERT) && int_ack;

    always_comb begin
        w_win_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_id = 3'(i);
            end
        end
    end

    // Order matters: W1C, then edge set (set wins), then ack clear (ack wins).
    always_comb begin
        w_ipr_nxt = r_ipr;
        if (w_wr && (io_addr == c_ADDR_IPR)) begin
            w_ipr_nxt = w_ipr_nxt & ~io_wdata;
        end
        w_ipr_nxt = w_ipr_nxt | w_edge;
        if (w_ack_take) begin
            w_ipr_nxt = w_ipr_nxt & ~w_win_oh;
        end
    end

    // EOI acts on the pre-edge ISR, so a same-cycle ack set is never undone.
    always_comb begin
        w_isr_nxt = r_isr;
        if (w_wr && (io_addr == c_ADDR_EOI)) begin
            w_isr_nxt = r_isr & ~w_isr_low;
        end
        if (w_ack_take) begin
            w_isr_nxt = w_isr_nxt | w_win_oh;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_elig != 8'd0) begin
                    w_state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (int_ack) begin
                    w_state_nxt = S_ACK;
                end else if (w_elig == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                w_state_nxt = int_ack ? S_REL : S_IDLE;
            end
            S_REL: begin
                if (!int_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_sync1  <= 8'd0;
            r_sync2  <= 8'd0;
            r_prev   <= 8'd0;
            r_imr    <= 8'hFF;
            r_ipr    <= 8'd0;
            r_isr    <= 8'd0;
            r_int_id <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_ipr   <= w_ipr_nxt;
            r_isr   <= w_isr_nxt;
            if (w_wr && (io_addr == c_ADDR_IMR)) begin
                r_imr <= io_wdata;
            end
            if (w_ack_take) begin
                r_int_id <= w_win_id;
            end
        end
    end

    always_comb begin
        io_rdata = 8'h00;
        if (w_rd) begin
            case (io_addr)
                c_ADDR_IMR: io_rdata = r_imr;
                c_ADDR_IPR: io_rdata = r_ipr;
                c_ADDR_ISR: io_rdata = r_isr;
                default:    io_rdata = 8'h00;
            endcase
        end
    end

    assign interrupt = (r_state == S_ASSERT);
    assign int_id    = r_int_id;
    assign int_vec   = VEC_BASE + {27'd0, r_int_id, 2'b00};

endmodule
`default_nettype wire
